cpu_instr_loader: RTL and testbench

CPU_INSTR_LOADER -- requirements
Module: cpu_instr_loader

---
 rtl/cpu_instr_loader_if.sv | 26 ++
 rtl/cpu_instr_loader.sv | 116 +++++++++++
 tb/tb_cpu_instr_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader side; master is the stream source / memory side.
interface cpu_instr_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  cpu_halt;
  logic                  done;
  logic                  overflow;

  modport slave (
    input  in_data, in_valid,
    output in_ready, write_enable, write_addr, write_data, cpu_halt, done, overflow
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, write_enable, write_addr, write_data, cpu_halt, done, overflow
  );
endinterface

// File: rtl/cpu_instr_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory while
// holding the CPU halted; words beyond SIZE are drained and flagged as overflow.
//
// state   | meaning
// LEN_HI  | idle / waiting for word-count high byte
// LEN_LO  | waiting for word-count low byte
// WORD_HI | waiting for instruction high byte
// WORD_LO | waiting for instruction low byte
// WRITE   | one-cycle memory write (or overflow drop)
// DONE    | one-cycle completion pulse, releases CPU next cycle
module cpu_instr_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input logic               clk,
  input logic               rst,
  cpu_instr_loader_if.slave bus
);

  localparam logic [2:0] LEN_HI  = 3'd0;
  localparam logic [2:0] LEN_LO  = 3'd1;
  localparam logic [2:0] WORD_HI = 3'd2;
  localparam logic [2:0] WORD_LO = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  // 17 bits so SIZE up to 65536 compares correctly against the 16-bit counter
  localparam logic [16:0] SIZE_W = 17'(SIZE);

  logic [2:0]            state;
  logic [15:0]           len;
  logic [15:0]           cnt;
  logic [7:0]            hi_byte;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  halt_q;
  logic                  ovf_q;
  logic                  ready;
  logic                  accept;
  logic                  in_range;
  logic                  last_word;

  assign ready     = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == WORD_HI) || (state == WORD_LO);
  assign accept    = ready && bus.in_valid;
  assign in_range  = {1'b0, cnt} < SIZE_W;
  assign last_word = (cnt + 16'd1) == len;

  assign bus.in_ready     = ready;
  assign bus.write_enable = (state == WRITE) && in_range;
  assign bus.write_addr   = addr_q;
  assign bus.write_data   = data_q;
  assign bus.cpu_halt     = halt_q;
  assign bus.done         = (state == DONE);
  assign bus.overflow     = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LEN_HI;
      len     <= '0;
      cnt     <= '0;
      hi_byte <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      halt_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.in_data;
            halt_q    <= 1'b1;
            ovf_q     <= 1'b0;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.in_data;
            cnt      <= '0;
            state    <= ({len[15:8], bus.in_data} == 16'd0) ? DONE : WORD_HI;
          end
        end
        WORD_HI: begin
          if (accept) begin
            hi_byte <= bus.in_data;
            state   <= WORD_LO;
          end
        end
        WORD_LO: begin
          // Address/data are presented during WRITE, so load them here; out-of-range
          // words leave the last written address/data untouched.
          if (accept) begin
            if (in_range) begin
              addr_q <= cnt[ADDR_WIDTH-1:0];
              data_q <= DATA_WIDTH'({hi_byte, bus.in_data});
            end
            state <= WRITE;
          end
        end
        WRITE: begin
          if (!in_range) ovf_q <= 1'b1;
          cnt   <= cnt + 16'd1;
          state <= last_word ? DONE : WORD_HI;
        end
        DONE: begin
          halt_q <= 1'b0;
          state  <= LEN_HI;
        end
        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_instr_loader.sv
// Directed bench for cpu_instr_loader: a 1024-deep and a 4-deep instance share one
// stream driver; expected memory writes are queued at stimulus time and popped on writes.
module tb_cpu_instr_loader;

  typedef struct packed {
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       bv  = 1'b0;
  logic [7:0] bd  = 8'h00;

  int  total    = 0;
  int  bad      = 0;
  int  done_cnt = 0;
  wr_t q[$];

  always #5 clk = ~clk;

  cpu_instr_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) a_if ();
  cpu_instr_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2))  b_if ();

  assign a_if.in_data  = bd;
  assign b_if.in_data  = bd;
  assign a_if.in_valid = bv & ~sel;
  assign b_if.in_valid = bv & sel;

  cpu_instr_loader #(.DATA_WIDTH(16), .SIZE(1024), .ADDR_WIDTH(10)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  cpu_instr_loader #(.DATA_WIDTH(16), .SIZE(4), .ADDR_WIDTH(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  logic        ready_m, we_m, we_other, halt_m, done_m, ovf_m;
  logic [9:0]  addr_m;
  logic [15:0] data_m;

  assign ready_m  = sel ? b_if.in_ready     : a_if.in_ready;
  assign we_m     = sel ? b_if.write_enable : a_if.write_enable;
  assign we_other = sel ? a_if.write_enable : b_if.write_enable;
  assign halt_m   = sel ? b_if.cpu_halt     : a_if.cpu_halt;
  assign done_m   = sel ? b_if.done         : a_if.done;
  assign ovf_m    = sel ? b_if.overflow     : a_if.overflow;
  assign addr_m   = sel ? {8'b0, b_if.write_addr} : a_if.write_addr;
  assign data_m   = sel ? b_if.write_data   : a_if.write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [9:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  // Offer one byte and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    bd = b;
    bv = 1'b1;
    while (ready_m !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("ready_timeout", {31'b0, ready_m}, 32'd1);
    @(posedge clk); #1;
    bv = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_m !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", {31'b0, done_m}, 32'd1);
    check("halt_in_done", {31'b0, halt_m}, 32'd1);
    @(posedge clk); #1;
    check("done_one_pulse", {31'b0, done_m}, 32'd0);
    check("halt_released", {31'b0, halt_m}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (we_m === 1'b1) begin
        check("write_pending", {31'b0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          wr_t e;
          e = q.pop_front();
          check("write_addr", {22'b0, addr_m}, {22'b0, e.a});
          check("write_data", {16'b0, data_m}, {16'b0, e.d});
        end
        check("halt_in_write", {31'b0, halt_m}, 32'd1);
        check("ready_in_write", {31'b0, ready_m}, 32'd0);
      end
      if (we_other !== 1'b0) check("idle_instance_we", {31'b0, we_other}, 32'd0);
      if (done_m === 1'b1) begin
        done_cnt++;
        check("ready_in_done", {31'b0, ready_m}, 32'd0);
      end
    end
  end

  initial begin
    int dc0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", {31'b0, a_if.in_ready}, 32'd1);
    check("rst_we", {31'b0, a_if.write_enable}, 32'd0);
    check("rst_addr", {22'b0, a_if.write_addr}, 32'd0);
    check("rst_data", {16'b0, a_if.write_data}, 32'd0);
    check("rst_halt", {31'b0, a_if.cpu_halt}, 32'd0);
    check("rst_done", {31'b0, a_if.done}, 32'd0);
    check("rst_ovf", {31'b0, a_if.overflow}, 32'd0);
    check("rst_ovf_b", {31'b0, b_if.overflow}, 32'd0);

    // Two words, continuous stream
    push(10'd0, 16'h1234);
    push(10'd1, 16'hABCD);
    send(8'h00);
    check("halt_after_first_byte", {31'b0, halt_m}, 32'd1);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    send(8'hAB);
    send(8'hCD);
    wait_done();
    check("ovf_two_words", {31'b0, ovf_m}, 32'd0);

    // Empty program
    send(8'h00);
    send(8'h00);
    check("empty_done_next_cycle", {31'b0, done_m}, 32'd1);
    check("empty_ovf", {31'b0, ovf_m}, 32'd0);
    wait_done();

    // Overflow on the 4-deep instance
    sel = 1'b1;
    for (int i = 0; i < 4; i++) push(10'(i), 16'(i + 1));
    send(8'h00);
    send(8'h06);
    for (int i = 1; i <= 6; i++) begin
      send(8'h00);
      send(8'(i));
    end
    wait_done();
    check("ovf_set", {31'b0, ovf_m}, 32'd1);
    check("ovf_addr_hold", {22'b0, addr_m}, 32'd3);
    check("ovf_data_hold", {16'b0, data_m}, 32'h0004);

    // Next load clears overflow on its first byte
    push(10'd0, 16'h0007);
    send(8'h00);
    check("ovf_cleared", {31'b0, ovf_m}, 32'd0);
    send(8'h01);
    send(8'h00);
    send(8'h07);
    wait_done();
    check("ovf_after_small_load", {31'b0, ovf_m}, 32'd0);
    sel = 1'b0;

    // Single word with a one-cycle gap after every byte
    push(10'd0, 16'hBEEF);
    send(8'h00); @(posedge clk); #1;
    send(8'h01); @(posedge clk); #1;
    send(8'hBE); @(posedge clk); #1;
    send(8'hEF);
    wait_done();

    // Reset mid-load, with a valid byte during the reset cycle
    push(10'd0, 16'h1122);
    send(8'h00);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    rst = 1'b1;
    bv  = 1'b1;
    bd  = 8'h44;
    @(posedge clk); #1;
    rst = 1'b0;
    bv  = 1'b0;
    check("mid_rst_halt", {31'b0, halt_m}, 32'd0);
    check("mid_rst_ready", {31'b0, ready_m}, 32'd1);
    check("mid_rst_addr", {22'b0, addr_m}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_sb_empty", q.size(), 32'd0);
    push(10'd0, 16'h55AA);
    send(8'h00);
    send(8'h01);
    send(8'h55);
    send(8'hAA);
    wait_done();

    // Back-to-back loads
    dc0 = done_cnt;
    push(10'd0, 16'h1111);
    push(10'd0, 16'h2222);
    send(8'h00);
    send(8'h01);
    send(8'h11);
    send(8'h11);
    send(8'h00);
    send(8'h01);
    send(8'h22);
    send(8'h22);
    wait_done();
    check("b2b_done_pulses", done_cnt - dc0, 32'd2);

    check("sb_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
